// File: rtl/anti_droop_iir_mc_pkg.sv
// Shared types, default widths and the output clipping helper for the anti-droop IIR corrector.
package anti_droop_pkg;

    localparam int unsigned NCH_DEF       = 4;
    localparam int unsigned DIN_W_DEF     = 13;
    localparam int unsigned TAP_W_DEF     = 7;
    localparam int unsigned DOUT_W_DEF    = 16;
    localparam int unsigned ACC_W_DEF     = 48;
    localparam int unsigned GAIN_SH_DEF   = 3;
    localparam int unsigned IIR_SCALE_DEF = 15;
    localparam int unsigned CNT_W_DEF     = 12;

    typedef logic [0:0] fsm_state_t;
    localparam fsm_state_t StIdle = 1'b0;
    localparam fsm_state_t StRun  = 1'b1;

    // Clip a sign-extended value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] val,
                                                  input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (val > hi) return hi;
        if (val < lo) return lo;
        return val;
    endfunction

endpackage

// File: rtl/anti_droop_iir_mc_if.sv
// Control/data bundle between the ADC capture side and the anti-droop corrector.
interface anti_droop_iir_mc_if import anti_droop_pkg::*; #(
    parameter int unsigned NCH    = NCH_DEF,
    parameter int unsigned DIN_W  = DIN_W_DEF,
    parameter int unsigned TAP_W  = TAP_W_DEF,
    parameter int unsigned DOUT_W = DOUT_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);
    logic                    trig;
    logic                    mode;
    logic [CNT_W-1:0]        win_len;
    logic                    acc_clr_en;
    logic [NCH*DIN_W-1:0]    din;
    logic [NCH*TAP_W-1:0]    tap_weight;
    logic [NCH-1:0]          oflow_clr;
    logic [NCH-1:0]          oflow_detect;
    logic [NCH*DOUT_W-1:0]   dout;
    logic                    running;

    modport master (
        output trig, mode, win_len, acc_clr_en, din, tap_weight, oflow_clr,
        input  oflow_detect, dout, running
    );

    modport slave (
        input  trig, mode, win_len, acc_clr_en, din, tap_weight, oflow_clr,
        output oflow_detect, dout, running
    );
endinterface

// File: rtl/anti_droop_iir_mc_chan.sv
// One channel: input*tap integrator plus shifted direct term, saturated, with sticky overflow.
module anti_droop_chan import anti_droop_pkg::*; #(
    parameter int unsigned DIN_W     = DIN_W_DEF,
    parameter int unsigned TAP_W     = TAP_W_DEF,
    parameter int unsigned DOUT_W    = DOUT_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned GAIN_SH   = GAIN_SH_DEF,
    parameter int unsigned IIR_SCALE = IIR_SCALE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DIN_W-1:0]  din,
    input  logic signed [TAP_W-1:0]  weight,
    input  logic                     acc_en,
    input  logic                     acc_clr,
    input  logic                     oflow_clr,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     oflow_detect
);
    localparam int unsigned PROD_W   = DIN_W + TAP_W;
    localparam int unsigned SUM_W    = DOUT_W + 1;
    localparam int unsigned SLICE_LO = IIR_SCALE - GAIN_SH;
    localparam int unsigned SLICE_HI = SLICE_LO + DOUT_W - 1;

    logic signed [DIN_W-1:0]  din_q;
    logic signed [ACC_W-1:0]  mult_q, mult_d, acc_q, acc_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  direct, term, sum;
    logic signed [63:0]       sum_ext, sat_val;
    logic signed [DOUT_W-1:0] dout_d;
    logic                     sat_hit, slice_ovf, oflow_d;

    always_comb begin
        prod    = din * weight;
        mult_d  = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        acc_d   = acc_q;
        if (acc_clr)     acc_d = '0;
        else if (acc_en) acc_d = acc_q + mult_q;

        direct  = {{(SUM_W - DIN_W){din_q[DIN_W-1]}}, din_q} <<< GAIN_SH;
        term    = {acc_q[SLICE_HI], acc_q[SLICE_HI:SLICE_LO]};
        sum     = direct + term;
        sum_ext = {{(64 - SUM_W){sum[SUM_W-1]}}, sum};
        sat_val = sat_to(sum_ext, DOUT_W);
        sat_hit = (sat_val != sum_ext);
        dout_d  = sat_val[DOUT_W-1:0];

        // The bit just above the slice disagreeing with its MSB means the slice has wrapped.
        slice_ovf = (acc_q[SLICE_HI+1] != acc_q[SLICE_HI]);
        oflow_d   = oflow_detect;
        if (oflow_detect && oflow_clr)  oflow_d = 1'b0;
        else if (slice_ovf || sat_hit)  oflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q        <= '0;
            mult_q       <= '0;
            acc_q        <= '0;
            dout         <= '0;
            oflow_detect <= 1'b0;
        end else begin
            din_q        <= din;
            mult_q       <= mult_d;
            acc_q        <= acc_d;
            dout         <= dout_d;
            oflow_detect <= oflow_d;
        end
    end
endmodule

// File: rtl/anti_droop_iir_mc.sv
// Multi-channel anti-droop IIR corrector: trigger sync, tap staging, window FSM, channel array.
module anti_droop_iir_mc import anti_droop_pkg::*; #(
    parameter int unsigned NCH       = NCH_DEF,
    parameter int unsigned DIN_W     = DIN_W_DEF,
    parameter int unsigned TAP_W     = TAP_W_DEF,
    parameter int unsigned DOUT_W    = DOUT_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned GAIN_SH   = GAIN_SH_DEF,
    parameter int unsigned IIR_SCALE = IIR_SCALE_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    anti_droop_iir_mc_if.slave bus
);
    logic                    trig_a, trig_b, trig_edge;
    logic [NCH*TAP_W-1:0]    tap_s1, tap_s2;
    fsm_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    acc_en, acc_clr;
    logic [NCH*DOUT_W-1:0]   dout_w;
    logic [NCH-1:0]          oflow_w;

    assign trig_edge = trig_a & ~trig_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.mode) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (trig_edge) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    // A retrigger on the last window cycle restarts rather than exits.
                    if (trig_edge) begin
                        cnt_d = '0;
                    end else if (bus.win_len != '0 && cnt_q == bus.win_len - CNT_W'(1)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
        acc_en  = !bus.mode || (state_q == StRun);
        acc_clr = (trig_edge && bus.acc_clr_en) || (bus.mode && state_q == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_a  <= 1'b0;
            trig_b  <= 1'b0;
            tap_s1  <= '0;
            tap_s2  <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            trig_a  <= bus.trig;
            trig_b  <= trig_a;
            tap_s1  <= bus.tap_weight;
            tap_s2  <= tap_s1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        anti_droop_chan #(
            .DIN_W     (DIN_W),
            .TAP_W     (TAP_W),
            .DOUT_W    (DOUT_W),
            .ACC_W     (ACC_W),
            .GAIN_SH   (GAIN_SH),
            .IIR_SCALE (IIR_SCALE)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .din          (bus.din[i*DIN_W +: DIN_W]),
            .weight       (tap_s2[i*TAP_W +: TAP_W]),
            .acc_en       (acc_en),
            .acc_clr      (acc_clr),
            .oflow_clr    (bus.oflow_clr[i]),
            .dout         (dout_w[i*DOUT_W +: DOUT_W]),
            .oflow_detect (oflow_w[i])
        );
    end

    assign bus.dout         = dout_w;
    assign bus.oflow_detect = oflow_w;
    assign bus.running      = (state_q == StRun);
endmodule
